// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with per-slot dead time,
// leading-zero blanking and a once-per-frame input snapshot.
module sevenseg_scan_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYC    = 500,
  parameter int unsigned LZB_EN      = 1,
  localparam int unsigned IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg_L,
  output logic                  dp_L,
  output logic [DIGITS-1:0]     an_L,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    div_cnt;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_blank;
  logic                load_pending;

  logic [CNT_W-1:0]    div_cnt_nxt_c;
  logic [IDX_W-1:0]    idx_nxt_c;
  logic                tick_c;
  logic                snap_c;
  logic [DIGITS-1:0]   lz_dark_c;
  logic                zero_run_c;
  logic [3:0]          cur_nib_c;
  logic                lit_c;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot timer and digit rotation; snapshot lands on the frame boundary tick.
  always_comb begin
    tick_c        = (div_cnt == CNT_LAST);
    snap_c        = en && (load_pending || (tick_c && (digit_idx == IDX_LAST)));
    div_cnt_nxt_c = div_cnt + CNT_W'(1);
    idx_nxt_c     = digit_idx;
    if (tick_c) begin
      div_cnt_nxt_c = '0;
      idx_nxt_c     = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end
  end

  // A digit is leading-zero dark when it and every more significant nibble is zero.
  always_comb begin
    zero_run_c = 1'b1;
    lz_dark_c  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (snap_value[4*i +: 4] == 4'h0);
      if ((LZB_EN != 0) && (i != 0)) lz_dark_c[i] = zero_run_c;
    end
  end

  always_comb begin
    cur_nib_c = snap_value[4*int'(digit_idx) +: 4];
    lit_c     = en && (32'(div_cnt) >= DEAD_CYC)
                && !snap_blank[digit_idx] && !lz_dark_c[digit_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= '0;
      digit_idx    <= '0;
      snap_value   <= '0;
      snap_dp      <= '0;
      snap_blank   <= '0;
      load_pending <= 1'b1;
      seg_L        <= 7'h7F;
      dp_L         <= 1'b1;
      an_L         <= '1;
    end else begin
      if (en) begin
        div_cnt      <= div_cnt_nxt_c;
        digit_idx    <= idx_nxt_c;
        load_pending <= 1'b0;
      end
      if (snap_c) begin
        snap_value <= value;
        snap_dp    <= dp;
        snap_blank <= blank;
      end
      if (lit_c) begin
        seg_L <= hex_to_seg(cur_nib_c);
        dp_L  <= ~snap_dp[digit_idx];
        an_L  <= ~(DIGITS'(1) << digit_idx);
      end else begin
        seg_L <= 7'h7F;
        dp_L  <= 1'b1;
        an_L  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Directed bench for sevenseg_scan_mux: 4 digits, 8-cycle slots, 2-cycle dead time,
// one instance with leading-zero blanking and one without.
module tb_sevenseg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;

  logic [6:0]  seg_L,   seg_L_n;
  logic        dp_L,    dp_L_n;
  logic [3:0]  an_L,    an_L_n;
  logic [1:0]  digit_idx, digit_idx_n;

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;   // enabled edges since the last reset release
  int last_n   = 0;   // index of the most recent enabled edge

  always #5 clk = ~clk;

  sevenseg_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYC(2), .LZB_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank(blank),
    .seg_L(seg_L), .dp_L(dp_L), .an_L(an_L), .digit_idx(digit_idx)
  );

  sevenseg_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYC(2), .LZB_EN(0)) u_nolzb (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank(blank),
    .seg_L(seg_L_n), .dp_L(dp_L_n), .an_L(an_L_n), .digit_idx(digit_idx_n)
  );

  // Advance one clock, sampling point is the following falling edge.
  task automatic clk1();
    logic e;
    e = en && rst_n;
    @(negedge clk);
    if (e) begin
      last_n = ph;
      ph     = ph + 1;
    end
  endtask

  task automatic do_reset(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    rst_n = 1'b0; en = 1'b1; value = v; dp = d; blank = b;
    clk1();
    clk1();
    rst_n = 1'b1;
    ph    = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; value = 16'h12AF; dp = 4'b0100; blank = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      clk1();
      n_checks++;
      if ({an_L, seg_L, dp_L, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: got an=%h seg=%h dp=%b idx=%0d, want an=f seg=7f dp=1 idx=0",
                 i, an_L, seg_L, dp_L, digit_idx);
      end
    end
    rst_n = 1'b1;
    ph    = 0;
    for (int i = 0; i < 2; i++) begin
      clk1();
      n_checks++;
      if ({an_L, seg_L, dp_L, digit_idx, an_L_n} !== {4'hF, 7'h7F, 1'b1, 2'd0, 4'hF}) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d: got an=%h seg=%h dp=%b idx=%0d an_nolzb=%h, want an=f seg=7f dp=1 idx=0 an_nolzb=f",
                 i, an_L, seg_L, dp_L, digit_idx, an_L_n);
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] tbl [4];
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, lit;
    int         d;
    tbl = '{7'h0E, 7'h08, 7'h24, 7'h79};
    while (ph < 32) begin
      clk1();
      d     = (last_n / 8) % 4;
      lit   = (last_n % 8) >= 2;
      e_an  = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
      e_seg = lit ? tbl[d] : 7'h7F;
      e_dp  = !(lit && d == 2);
      n_checks++;
      if ({an_L, seg_L, dp_L} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL scan n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 last_n, an_L, seg_L, dp_L, e_an, e_seg, e_dp);
      end
      n_checks++;
      if ({an_L_n, seg_L_n, dp_L_n} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL scan_nolzb n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 last_n, an_L_n, seg_L_n, dp_L_n, e_an, e_seg, e_dp);
      end
      if ((last_n % 8) == 4) begin
        n_checks++;
        if (digit_idx !== 2'(d)) begin
          n_fail++;
          $display("FAIL scan_idx n=%0d: got %0d, want %0d", last_n, digit_idx, d);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] segt [4];
    logic [3:0] mask;
    logic [6:0] e_seg, e_seg_n;
    logic [3:0] e_an, e_an_n;
    logic       e_dp, e_dp_n, on, lit;
    int         d;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        segt = '{7'h40, 7'h12, 7'h40, 7'h40};
        mask = 4'b0011;
        do_reset(16'h0050, 4'b1000, 4'b0000);
      end else begin
        segt = '{7'h40, 7'h40, 7'h40, 7'h40};
        mask = 4'b0001;
        do_reset(16'h0000, 4'b1000, 4'b0000);
      end
      while (ph < 32) begin
        clk1();
        d       = (last_n / 8) % 4;
        on      = (last_n % 8) >= 2;
        lit     = on && mask[d];
        e_an    = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
        e_seg   = lit ? segt[d] : 7'h7F;
        e_dp    = !(lit && d == 3);
        e_an_n  = on ? (4'hF ^ (4'b0001 << d)) : 4'hF;
        e_seg_n = on ? segt[d] : 7'h7F;
        e_dp_n  = !(on && d == 3);
        n_checks++;
        if ({an_L, seg_L, dp_L} !== {e_an, e_seg, e_dp}) begin
          n_fail++;
          $display("FAIL lzb case=%0d n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                   c, last_n, an_L, seg_L, dp_L, e_an, e_seg, e_dp);
        end
        n_checks++;
        if ({an_L_n, seg_L_n, dp_L_n} !== {e_an_n, e_seg_n, e_dp_n}) begin
          n_fail++;
          $display("FAIL lzb_off case=%0d n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                   c, last_n, an_L_n, seg_L_n, dp_L_n, e_an_n, e_seg_n, e_dp_n);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       lit;
    int         d;
    do_reset(16'h1111, 4'b0000, 4'b0000);
    while (ph < 64) begin
      clk1();
      if (last_n == 12) value = 16'h2222;
      d     = (last_n / 8) % 4;
      lit   = (last_n % 8) >= 2;
      e_an  = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
      e_seg = !lit ? 7'h7F : (last_n < 32) ? 7'h79 : 7'h24;
      n_checks++;
      if ({an_L, seg_L, dp_L} !== {e_an, e_seg, 1'b1}) begin
        n_fail++;
        $display("FAIL tear_free n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 last_n, an_L, seg_L, dp_L, e_an, e_seg);
      end
    end
  endtask

  task automatic test_en_blank();
    logic [6:0] tbl [4];
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       lit;
    int         d;
    tbl = '{7'h0E, 7'h08, 7'h24, 7'h79};
    do_reset(16'h12AF, 4'b0000, 4'b0000);
    while (ph < 13) clk1();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      n_checks++;
      if ({an_L, seg_L, dp_L, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd1}) begin
        n_fail++;
        $display("FAIL en_off cyc=%0d: got an=%h seg=%h dp=%b idx=%0d, want an=f seg=7f dp=1 idx=1",
                 i, an_L, seg_L, dp_L, digit_idx);
      end
    end
    en    = 1'b1;
    blank = 4'b0001;
    while (ph < 64) begin
      clk1();
      d     = (last_n / 8) % 4;
      lit   = ((last_n % 8) >= 2) && !(last_n >= 32 && d == 0);
      e_an  = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
      e_seg = lit ? tbl[d] : 7'h7F;
      n_checks++;
      if ({an_L, seg_L, dp_L} !== {e_an, e_seg, 1'b1}) begin
        n_fail++;
        $display("FAIL en_resume_blank n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 last_n, an_L, seg_L, dp_L, e_an, e_seg);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(16'h12AF, 4'b0000, 4'b0000);
    while (ph < 21) clk1();
    n_checks++;
    if (digit_idx !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got idx=%0d, want 2", digit_idx);
    end
    rst_n = 1'b0;
    clk1();
    n_checks++;
    if ({an_L, seg_L, dp_L, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got an=%h seg=%h dp=%b idx=%0d, want an=f seg=7f dp=1 idx=0",
               an_L, seg_L, dp_L, digit_idx);
    end
    rst_n = 1'b1;
    ph    = 0;
    clk1();
    clk1();
    clk1();
    n_checks++;
    if ({an_L, seg_L, dp_L} !== {4'hE, 7'h0E, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got an=%h seg=%h dp=%b, want an=e seg=0e dp=1",
               an_L, seg_L, dp_L);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; value = '0; dp = '0; blank = '0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_lzb();
    test_tear_free();
    test_en_blank();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
